// File: rtl/calib_sweep_fsm.sv
// calib_sweep_fsm: walks every LED address bit, optionally in true and
// complemented polarity. For each pass it loads an LED pattern and hands one
// step to the calibration FSM. Each phase has a watchdog with bounded retries.
// The block also supports abort and a sticky error state.
//
// Ports:
//   clk_in, rst_n_in            clock, async active-low reset
//   start_in, abort_in          user controls
//   led_display_valid_in        pattern for current bit/polarity is shown
//   calib_busy_in               calibration step FSM not idle
//   led_addr_bit_sel_out        address bit under calibration
//   led_polarity_out            0 = bit-set LEDs lit, 1 = complement
//   led_addr_bit_sel_start_out  one-cycle pulse: load new pattern
//   calibration_start_out       step request, held until busy seen
//   calibration_first_out       high from sweep start to first accepted step
//   busy_out, done_out, error_out, state_out  status
module calib_sweep_fsm #(
  parameter int unsigned NUM_LEDS               = 50,
  parameter int unsigned LED_ADDRESS_WIDTH      = $clog2(NUM_LEDS),
  parameter int unsigned LED_ADDR_BIT_SEL_WIDTH =
    (LED_ADDRESS_WIDTH > 1) ? $clog2(LED_ADDRESS_WIDTH) : 1,
  parameter int unsigned COMPLEMENT_PASS        = 1,
  parameter int unsigned TIMEOUT_CYCLES         = 1_000_000,
  parameter int unsigned MAX_RETRIES            = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              start_in,
  input  logic                              abort_in,
  input  logic                              led_display_valid_in,
  input  logic                              calib_busy_in,
  output logic [LED_ADDR_BIT_SEL_WIDTH-1:0] led_addr_bit_sel_out,
  output logic                              led_polarity_out,
  output logic                              led_addr_bit_sel_start_out,
  output logic                              calibration_start_out,
  output logic                              calibration_first_out,
  output logic                              busy_out,
  output logic                              done_out,
  output logic                              error_out,
  output logic [2:0]                        state_out
);

  localparam int unsigned SEL_W = LED_ADDR_BIT_SEL_WIDTH;
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [SEL_W-1:0] LAST_BIT  = SEL_W'(LED_ADDRESS_WIDTH - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_DISPLAY  = 3'd0,
    ST_SHOW_LED = 3'd1,
    ST_ARM_STEP = 3'd2,
    ST_RUN_STEP = 3'd3,
    ST_ERROR    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               pol_q, pol_d;
  logic [RTY_W-1:0]   rty_q, rty_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               pulse_q, pulse_d;
  logic               cstart_q, cstart_d;
  logic               first_q, first_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic               active_c;
  logic               timeout_c;

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_DISPLAY;
      sel_q    <= '0;
      pol_q    <= 1'b0;
      rty_q    <= '0;
      tmr_q    <= '0;
      pulse_q  <= 1'b0;
      cstart_q <= 1'b0;
      first_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      pol_q    <= pol_d;
      rty_q    <= rty_d;
      tmr_q    <= tmr_d;
      pulse_q  <= pulse_d;
      cstart_q <= cstart_d;
      first_q  <= first_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign active_c  = (state_q == ST_SHOW_LED) || (state_q == ST_ARM_STEP) ||
                     (state_q == ST_RUN_STEP);
  assign timeout_c = (TIMEOUT_CYCLES != 0) && (tmr_q == TMR_LIMIT);

  // Next-state and next-output logic; priority abort > timeout > normal
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    pol_d    = pol_q;
    rty_d    = rty_q;
    cstart_d = cstart_q;
    first_d  = first_q;
    pulse_d  = 1'b0;
    done_d   = 1'b0;
    tmr_d    = tmr_q;

    case (state_q)
      ST_DISPLAY, ST_ERROR: begin
        if (start_in) begin
          state_d  = ST_SHOW_LED;
          sel_d    = '0;
          pol_d    = 1'b0;
          rty_d    = '0;
          first_d  = 1'b1;
          cstart_d = 1'b0;
          pulse_d  = 1'b1;
        end
      end
      ST_SHOW_LED, ST_ARM_STEP, ST_RUN_STEP: begin
        if (abort_in) begin
          state_d  = ST_DISPLAY;
          cstart_d = 1'b0;
          first_d  = 1'b0;
          rty_d    = '0;
        end else if (timeout_c) begin
          cstart_d = 1'b0;
          if (rty_q < RTY_LIMIT) begin
            // Retry the same bit/polarity with a fresh pattern load
            state_d = ST_SHOW_LED;
            rty_d   = rty_q + RTY_W'(1);
            pulse_d = 1'b1;
          end else begin
            state_d = ST_ERROR;
            first_d = 1'b0;
          end
        end else if (state_q == ST_SHOW_LED) begin
          // pulse_q marks the entry cycle, where valid is stale
          if (!pulse_q && led_display_valid_in) begin
            state_d  = ST_ARM_STEP;
            cstart_d = 1'b1;
          end
        end else if (state_q == ST_ARM_STEP) begin
          if (calib_busy_in) begin
            state_d  = ST_RUN_STEP;
            cstart_d = 1'b0;
            first_d  = 1'b0;
          end
        end else if (!calib_busy_in) begin
          rty_d = '0;
          if ((COMPLEMENT_PASS != 0) && !pol_q) begin
            state_d = ST_SHOW_LED;
            pol_d   = 1'b1;
            pulse_d = 1'b1;
          end else if (sel_q == LAST_BIT) begin
            state_d = ST_DISPLAY;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SHOW_LED;
            sel_d   = sel_q + SEL_W'(1);
            pol_d   = 1'b0;
            pulse_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = ST_DISPLAY;
        cstart_d = 1'b0;
        first_d  = 1'b0;
      end
    endcase

    // Watchdog restarts on every state entry, including retry re-entry
    if ((state_d != state_q) || pulse_d || !active_c) begin
      tmr_d = '0;
    end else if (TIMEOUT_CYCLES != 0) begin
      tmr_d = tmr_q + TMR_W'(1);
    end

    busy_d  = (state_d == ST_SHOW_LED) || (state_d == ST_ARM_STEP) ||
              (state_d == ST_RUN_STEP);
    error_d = (state_d == ST_ERROR);
  end

  assign led_addr_bit_sel_out       = sel_q;
  assign led_polarity_out           = pol_q;
  assign led_addr_bit_sel_start_out = pulse_q;
  assign calibration_start_out      = cstart_q;
  assign calibration_first_out      = first_q;
  assign busy_out                   = busy_q;
  assign done_out                   = done_q;
  assign error_out                  = error_q;
  assign state_out                  = state_q;

endmodule

// File: tb/tb_calib_sweep_fsm.sv
// Directed bench for calib_sweep_fsm: instance A (50 LEDs, complement pass,
// 16-cycle watchdog, 2 retries) and instance B (8 LEDs, single pass).
module tb_calib_sweep_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance A
  logic       a_start, a_abort, a_valid, a_busy_in;
  logic [2:0] a_sel;
  logic       a_pol, a_pulse, a_cstart, a_first, a_busy, a_done, a_err;
  logic [2:0] a_state;
  logic       a_model_en, a_hang;
  int         a_hold;
  int         a_tags[$];
  int         a_done_cnt, a_first_bad;

  // Instance B
  logic       b_start, b_abort, b_valid, b_busy_in;
  logic [1:0] b_sel;
  logic       b_pol, b_pulse, b_cstart, b_first, b_busy, b_done, b_err;
  logic [2:0] b_state;
  int         b_hold;
  int         b_tags[$];
  int         b_done_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  calib_sweep_fsm #(
    .NUM_LEDS(50), .COMPLEMENT_PASS(1), .TIMEOUT_CYCLES(16), .MAX_RETRIES(2)
  ) u_dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(a_start), .abort_in(a_abort),
    .led_display_valid_in(a_valid), .calib_busy_in(a_busy_in),
    .led_addr_bit_sel_out(a_sel), .led_polarity_out(a_pol),
    .led_addr_bit_sel_start_out(a_pulse), .calibration_start_out(a_cstart),
    .calibration_first_out(a_first), .busy_out(a_busy), .done_out(a_done),
    .error_out(a_err), .state_out(a_state)
  );

  calib_sweep_fsm #(
    .NUM_LEDS(8), .COMPLEMENT_PASS(0), .TIMEOUT_CYCLES(16), .MAX_RETRIES(2)
  ) u_dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(b_start), .abort_in(b_abort),
    .led_display_valid_in(b_valid), .calib_busy_in(b_busy_in),
    .led_addr_bit_sel_out(b_sel), .led_polarity_out(b_pol),
    .led_addr_bit_sel_start_out(b_pulse), .calibration_start_out(b_cstart),
    .calibration_first_out(b_first), .busy_out(b_busy), .done_out(b_done),
    .error_out(b_err), .state_out(b_state)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Step models: raise busy when a request is seen, hold it, then drop it
  always @(negedge clk) begin
    if (a_model_en) begin
      if (a_busy_in) begin
        if (a_hold == 0) a_busy_in = 1'b0;
        else a_hold--;
      end else if (a_cstart && !(a_hang && a_sel == 3'd2)) begin
        a_busy_in = 1'b1;
        a_hold    = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (b_busy_in) begin
      if (b_hold == 0) b_busy_in = 1'b0;
      else b_hold--;
    end else if (b_cstart) begin
      b_busy_in = 1'b1;
      b_hold    = 1;
    end
  end

  // Pulse/done monitors; tag = bit*2 + polarity
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_pulse) a_tags.push_back(int'(a_sel) * 2 + int'(a_pol));
      if (a_done) a_done_cnt++;
      if (a_state == 3'd3 && a_first) a_first_bad++;
      if (b_pulse) b_tags.push_back(int'(b_sel) * 2 + int'(b_pol));
      if (b_done) b_done_cnt++;
    end
  end

  initial begin
    int done_before;
    int exp_to[7] = '{0, 1, 2, 3, 4, 4, 4};
    rst_n = 1'b0;
    a_start = 0; a_abort = 0; a_valid = 0; a_busy_in = 0;
    a_model_en = 0; a_hang = 0; a_hold = 0; a_done_cnt = 0; a_first_bad = 0;
    b_start = 0; b_abort = 0; b_valid = 1; b_busy_in = 0; b_hold = 0; b_done_cnt = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_state", a_state, 0);
    chk("rst_outs", {a_sel, a_pol, a_pulse, a_cstart, a_first, a_busy, a_done, a_err}, 0);
    chk("rst_b_outs", {b_sel, b_pol, b_pulse, b_cstart, b_first, b_busy, b_done, b_err, b_state}, 0);
    rst_n = 1'b1;

    // Start timing; start held high; valid high during pulse cycle
    @(negedge clk);
    a_tags.delete();
    a_valid = 1'b1;
    a_start = 1'b1;
    @(negedge clk);
    chk("n1_state", a_state, 1);
    chk("n1_pulse", a_pulse, 1);
    chk("n1_first", a_first, 1);
    chk("n1_busy", a_busy, 1);
    chk("n1_cstart", a_cstart, 0);
    @(negedge clk);
    chk("n2_pulse", a_pulse, 0);
    chk("n2_cstart_ignored", a_cstart, 0);
    @(negedge clk);
    chk("n3_cstart", a_cstart, 1);
    chk("n3_state", a_state, 2);
    a_model_en = 1'b1;

    // Full sweep with complement pass
    for (int i = 0; i < 2000 && !a_done; i++) begin
      @(negedge clk);
      if (a_tags.size() >= 6) a_start = 1'b0;
    end
    chk("sweep_done", a_done, 1);
    chk("sweep_end_state", a_state, 0);
    chk("sweep_end_busy", a_busy, 0);
    repeat (5) @(negedge clk);
    chk("sweep_done_once", a_done_cnt, 1);
    chk("sweep_pulses", a_tags.size(), 12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("sweep_tag%0d", i), (i < a_tags.size()) ? a_tags[i] : -1, i);
    chk("first_low_in_run", a_first_bad, 0);

    // Abort in ARM_STEP, same cycle as busy
    a_model_en = 1'b0;
    a_busy_in  = 1'b0;
    a_start    = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_pre_state", a_state, 2);
    done_before = a_done_cnt;
    a_abort   = 1'b1;
    a_busy_in = 1'b1;
    @(negedge clk);
    chk("abort_state", a_state, 0);
    chk("abort_cstart", a_cstart, 0);
    chk("abort_first", a_first, 0);
    chk("abort_no_done", a_done, 0);
    a_abort   = 1'b0;
    a_busy_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_done_cnt", a_done_cnt, done_before);

    // Timeouts at bit 2 with two retries, then ERROR
    a_tags.delete();
    a_hang     = 1'b1;
    a_model_en = 1'b1;
    a_start    = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 1000 && !a_err; i++) @(negedge clk);
    chk("to_error", a_err, 1);
    chk("to_state", a_state, 4);
    chk("to_sel", a_sel, 2);
    chk("to_pol", a_pol, 0);
    chk("to_cstart", a_cstart, 0);
    chk("to_busy", a_busy, 0);
    chk("to_pulses", a_tags.size(), 7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("to_tag%0d", i), (i < a_tags.size()) ? a_tags[i] : -1, exp_to[i]);
    repeat (3) @(negedge clk);
    chk("to_sticky", a_state, 4);

    // Restart out of ERROR
    a_hang  = 1'b0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("restart_err", a_err, 0);
    chk("restart_state", a_state, 1);
    chk("restart_sel", a_sel, 0);
    chk("restart_pulse", a_pulse, 1);

    // Asynchronous reset mid-sweep at RUN_STEP, bit 3
    for (int i = 0; i < 1000 && !(a_sel == 3'd3 && a_state == 3'd3); i++) @(negedge clk);
    chk("mid_reached", {a_sel, a_state}, {3'd3, 3'd3});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", a_state, 0);
    chk("mid_rst_outs", {a_sel, a_pol, a_pulse, a_cstart, a_first, a_busy, a_done, a_err}, 0);
    a_model_en = 1'b0;
    a_busy_in  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Instance B: single-polarity sweep of 3 bits
    @(negedge clk);
    b_tags.delete();
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 1000 && !b_done; i++) @(negedge clk);
    chk("b_done", b_done, 1);
    repeat (3) @(negedge clk);
    chk("b_done_once", b_done_cnt, 1);
    chk("b_pulses", b_tags.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("b_tag%0d", i), (i < b_tags.size()) ? b_tags[i] : -1, i * 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
